// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_core slice.
//   - opcode constants for the supported instruction subset
//   - FSM state enum, addressing-mode and register-select enums
//   - status bit positions and reset value
//   - decode helpers (mode, store flag, register select) and load flag update
package cpu_pkg;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
  localparam logic [7:0] OP_LDX_ABS = 8'hAE;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
  localparam logic [7:0] OP_LDY_ABS = 8'hAC;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_STX_ZP  = 8'h86;
  localparam logic [7:0] OP_STX_ABS = 8'h8E;
  localparam logic [7:0] OP_STY_ZP  = 8'h84;
  localparam logic [7:0] OP_STY_ABS = 8'h8C;

  typedef enum logic [2:0] {
    ST_RESET_LO, ST_RESET_HI, ST_FETCH, ST_OPERAND_LO,
    ST_OPERAND_HI, ST_READ, ST_WRITE, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    MODE_IMP, MODE_IMM, MODE_ZP, MODE_ABS, MODE_ILLEGAL
  } mode_e;

  typedef enum logic [1:0] { REG_A, REG_X, REG_Y } reg_e;

  localparam int         STATUS_N     = 7;
  localparam int         STATUS_Z     = 1;
  localparam logic [7:0] STATUS_RESET = 8'h34;

  function automatic mode_e op_mode(input logic [7:0] op);
    mode_e m;
    case (op)
      OP_NOP:                                            m = MODE_IMP;
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM:                m = MODE_IMM;
      OP_LDA_ZP, OP_LDX_ZP, OP_LDY_ZP,
      OP_STA_ZP, OP_STX_ZP, OP_STY_ZP:                   m = MODE_ZP;
      OP_LDA_ABS, OP_LDX_ABS, OP_LDY_ABS,
      OP_STA_ABS, OP_STX_ABS, OP_STY_ABS:                m = MODE_ABS;
      default:                                           m = MODE_ILLEGAL;
    endcase
    return m;
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    logic s;
    case (op)
      OP_STA_ZP, OP_STX_ZP, OP_STY_ZP,
      OP_STA_ABS, OP_STX_ABS, OP_STY_ABS: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic reg_e op_reg(input logic [7:0] op);
    reg_e r;
    case (op)
      OP_LDX_IMM, OP_LDX_ZP, OP_LDX_ABS, OP_STX_ZP, OP_STX_ABS: r = REG_X;
      OP_LDY_IMM, OP_LDY_ZP, OP_LDY_ABS, OP_STY_ZP, OP_STY_ABS: r = REG_Y;
      default:                                                  r = REG_A;
    endcase
    return r;
  endfunction

  // Loads update N and Z from the loaded value; other status bits pass through.
  function automatic logic [7:0] load_flags(input logic [7:0] status,
                                            input logic [7:0] value);
    logic [7:0] s;
    s           = status;
    s[STATUS_N] = value[7];
    s[STATUS_Z] = (value == 8'h00);
    return s;
  endfunction

endpackage

// File: rtl/cpu_tick_divider.sv
// cpu_tick_divider: one-clock tick every CLOCK_DIVIDER clocks.
//   clock_i : system clock
//   reset_i : synchronous active-high reset (counter cleared to 0)
//   tick_o  : high for one clock in every CLOCK_DIVIDER; the first tick is
//             CLOCK_DIVIDER clocks after reset_i deasserts
module cpu_tick_divider #(
  parameter int CLOCK_DIVIDER = 12
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLOCK_DIVIDER - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? 8'd0 : count_q + 8'd1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) count_q <= 8'd0;
    else         count_q <= count_d;
  end

  // With CLOCK_DIVIDER=1, LAST is 0 and the tick is permanently high.
  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/cpu_core.sv
// cpu_core: minimal 8-bit load/store core with a ticked bus handshake.
//   clock_i/reset_i        : clock, synchronous active-high reset
//   data_i/data_valid_i    : read data and its valid (sampled on ticks only)
//   address_o/address_valid_o : bus address and its valid
//   data_o/data_valid_o    : write data and write strobe (held one tick period)
//   instr_done_o           : one-clock pulse when an instruction retires
//   halted_o               : core is in HALT
//   program_counter_o, accumulator_o, index_x_o, index_y_o, status_o :
//                            architectural registers
// Optional feature: define CPU_ILLEGAL_OP_TRAP_EN to halt on unsupported
// opcodes; otherwise they execute as a 2-tick NOP and halted_o is 0.
module cpu_core #(
  parameter int          CLOCK_DIVIDER = 12,
  parameter logic [15:0] RESET_VECTOR  = 16'hFFFC
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  output logic [15:0] address_o,
  output logic        address_valid_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        instr_done_o,
  output logic        halted_o,
  output logic [15:0] program_counter_o,
  output logic [7:0]  accumulator_o,
  output logic [7:0]  index_x_o,
  output logic [7:0]  index_y_o,
  output logic [7:0]  status_o
);
  import cpu_pkg::*;

  logic tick;

  cpu_tick_divider #(.CLOCK_DIVIDER(CLOCK_DIVIDER)) u_tick (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d;
  logic        addr_valid_q, addr_valid_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wstrobe_q, wstrobe_d;
  logic        done_q, done_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, status_q, status_d;
  logic [7:0]  opcode_q, opcode_d, op_lo_q, op_lo_d;

  logic [15:0] pc_inc, ea, retire_addr;
  logic        load_en, write_en, retire_en;
  logic [7:0]  load_val, store_val;
  mode_e       mode_q;
  logic        store_q;
  reg_e        rsel_q;

  assign pc_inc = pc_q + 16'd1;
  assign mode_q  = op_mode(opcode_q);
  assign store_q = op_is_store(opcode_q);
  assign rsel_q  = op_reg(opcode_q);

  always_comb begin
    case (rsel_q)
      REG_X:   store_val = x_q;
      REG_Y:   store_val = y_q;
      default: store_val = a_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    wdata_d      = wdata_q;
    wstrobe_d    = wstrobe_q;
    done_d       = 1'b0;
    a_d          = a_q;
    x_d          = x_q;
    y_d          = y_q;
    status_d     = status_q;
    opcode_d     = opcode_q;
    op_lo_d      = op_lo_q;
    load_en      = 1'b0;
    load_val     = 8'h00;
    write_en     = 1'b0;
    retire_en    = 1'b0;
    retire_addr  = pc_q;
    ea           = 16'h0000;

    if (tick) begin
      case (state_q)
        ST_RESET_LO: if (data_valid_i) begin
          pc_d    = {pc_q[15:8], data_i};
          addr_d  = RESET_VECTOR + 16'd1;
          state_d = ST_RESET_HI;
        end
        ST_RESET_HI: if (data_valid_i) begin
          pc_d    = {data_i, pc_q[7:0]};
          addr_d  = {data_i, pc_q[7:0]};
          state_d = ST_FETCH;
        end
        ST_FETCH: if (data_valid_i) begin
          opcode_d = data_i;
`ifdef CPU_ILLEGAL_OP_TRAP_EN
          if (op_mode(data_i) == MODE_ILLEGAL) begin
            // PC stays on the opcode so the trap site is visible.
            addr_valid_d = 1'b0;
            state_d      = ST_HALT;
          end else
`endif
          begin
            pc_d    = pc_inc;
            addr_d  = pc_inc;
            state_d = ST_OPERAND_LO;
            // Implied ops spend their second tick internally: no bus read.
            if (op_mode(data_i) == MODE_IMP || op_mode(data_i) == MODE_ILLEGAL)
              addr_valid_d = 1'b0;
          end
        end
        ST_OPERAND_LO: begin
          if (mode_q == MODE_IMP || mode_q == MODE_ILLEGAL) begin
            retire_en = 1'b1;
          end else if (data_valid_i) begin
            pc_d    = pc_inc;
            op_lo_d = data_i;
            case (mode_q)
              MODE_IMM: begin
                load_en     = 1'b1;
                load_val    = data_i;
                retire_en   = 1'b1;
                retire_addr = pc_inc;
              end
              MODE_ZP: begin
                ea = {8'h00, data_i};
                if (store_q) write_en = 1'b1;
                else begin
                  addr_d  = ea;
                  state_d = ST_READ;
                end
              end
              default: begin
                addr_d  = pc_inc;
                state_d = ST_OPERAND_HI;
              end
            endcase
          end
        end
        ST_OPERAND_HI: if (data_valid_i) begin
          pc_d = pc_inc;
          ea   = {data_i, op_lo_q};
          if (store_q) write_en = 1'b1;
          else begin
            addr_d  = ea;
            state_d = ST_READ;
          end
        end
        ST_READ: if (data_valid_i) begin
          load_en   = 1'b1;
          load_val  = data_i;
          retire_en = 1'b1;
        end
        ST_WRITE: begin
          // The write completes on this tick whatever data_valid_i says.
          wstrobe_d = 1'b0;
          wdata_d   = 8'h00;
          retire_en = 1'b1;
        end
        default: ;
      endcase
    end

    if (load_en) begin
      status_d = load_flags(status_q, load_val);
      case (rsel_q)
        REG_X:   x_d = load_val;
        REG_Y:   y_d = load_val;
        default: a_d = load_val;
      endcase
    end
    if (write_en) begin
      addr_d       = ea;
      addr_valid_d = 1'b1;
      wdata_d      = store_val;
      wstrobe_d    = 1'b1;
      state_d      = ST_WRITE;
    end
    if (retire_en) begin
      addr_d       = retire_addr;
      addr_valid_d = 1'b1;
      done_d       = 1'b1;
      state_d      = ST_FETCH;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_RESET_LO;
      pc_q         <= 16'h0000;
      addr_q       <= RESET_VECTOR;
      addr_valid_q <= 1'b1;
      wdata_q      <= 8'h00;
      wstrobe_q    <= 1'b0;
      done_q       <= 1'b0;
      a_q          <= 8'h00;
      x_q          <= 8'h00;
      y_q          <= 8'h00;
      status_q     <= STATUS_RESET;
      opcode_q     <= 8'h00;
      op_lo_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wdata_q      <= wdata_d;
      wstrobe_q    <= wstrobe_d;
      done_q       <= done_d;
      a_q          <= a_d;
      x_q          <= x_d;
      y_q          <= y_d;
      status_q     <= status_d;
      opcode_q     <= opcode_d;
      op_lo_q      <= op_lo_d;
    end
  end

  assign address_o         = addr_q;
  assign address_valid_o   = addr_valid_q;
  assign data_o            = wdata_q;
  assign data_valid_o      = wstrobe_q;
  assign instr_done_o      = done_q;
  assign program_counter_o = pc_q;
  assign accumulator_o     = a_q;
  assign index_x_o         = x_q;
  assign index_y_o         = y_q;
  assign status_o          = status_q;
`ifdef CPU_ILLEGAL_OP_TRAP_EN
  assign halted_o          = (state_q == ST_HALT);
`else
  assign halted_o          = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed bench for cpu_core.
//   dut_a runs with CLOCK_DIVIDER=1 (tick every clock), dut_b with 12.
//   Each has its own combinational memory model feeding data_i.
module tb_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, dv_a, dv_b;
  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic [7:0]  rd_a, rd_b;

  logic [15:0] addr_a, pc_a, addr_b, pc_b;
  logic        av_a, dvo_a, done_a, halt_a, av_b, dvo_b, done_b, halt_b;
  logic [7:0]  do_a, acc_a, x_a, y_a, st_a, do_b, acc_b, x_b, y_b, st_b;

  assign rd_a = mem_a[addr_a];
  assign rd_b = mem_b[addr_b];

  cpu_core #(.CLOCK_DIVIDER(1), .RESET_VECTOR(16'hFFFC)) dut_a (
    .clock_i(clk), .reset_i(rst_a), .data_i(rd_a), .data_valid_i(dv_a),
    .address_o(addr_a), .address_valid_o(av_a), .data_o(do_a),
    .data_valid_o(dvo_a), .instr_done_o(done_a), .halted_o(halt_a),
    .program_counter_o(pc_a), .accumulator_o(acc_a), .index_x_o(x_a),
    .index_y_o(y_a), .status_o(st_a)
  );

  cpu_core #(.CLOCK_DIVIDER(12), .RESET_VECTOR(16'hFFFC)) dut_b (
    .clock_i(clk), .reset_i(rst_b), .data_i(rd_b), .data_valid_i(dv_b),
    .address_o(addr_b), .address_valid_o(av_b), .data_o(do_b),
    .data_valid_o(dvo_b), .instr_done_o(done_b), .halted_o(halt_b),
    .program_counter_o(pc_b), .accumulator_o(acc_b), .index_x_o(x_b),
    .index_y_o(y_b), .status_o(st_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int          hi_cnt, rise_cnt, done_cnt;
  logic        prev_s, w_av;
  logic [15:0] w_addr;
  logic [7:0]  w_data;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; dv_a = 1'b1; dv_b = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    // dut_a: vector -> 8000; LDA #00, LDX #FF, LDA $1234, NOP, opcode 02
    mem_a[16'hFFFC] = 8'h00; mem_a[16'hFFFD] = 8'h80;
    mem_a[16'h8000] = 8'hA9; mem_a[16'h8001] = 8'h00;
    mem_a[16'h8002] = 8'hA2; mem_a[16'h8003] = 8'hFF;
    mem_a[16'h8004] = 8'hAD; mem_a[16'h8005] = 8'h34; mem_a[16'h8006] = 8'h12;
    mem_a[16'h8007] = 8'hEA; mem_a[16'h8008] = 8'h02;
    mem_a[16'h1234] = 8'h5A;
    // dut_b: vector -> FFFF; LDA #42 with operand wrapping to 0000,
    // then LDY #77, STY $0200, STA $10
    mem_b[16'hFFFC] = 8'hFF; mem_b[16'hFFFD] = 8'hFF;
    mem_b[16'hFFFF] = 8'hA9; mem_b[16'h0000] = 8'h42;
    mem_b[16'h0001] = 8'hA0; mem_b[16'h0002] = 8'h77;
    mem_b[16'h0003] = 8'h8C; mem_b[16'h0004] = 8'h00; mem_b[16'h0005] = 8'h02;
    mem_b[16'h0006] = 8'h85; mem_b[16'h0007] = 8'h10;

    clk_n(3);
    check("rst_addr",   addr_a, 16'hFFFC);
    check("rst_av",     av_a,   1'b1);
    check("rst_dvo",    dvo_a,  1'b0);
    check("rst_do",     do_a,   8'h00);
    check("rst_done",   done_a, 1'b0);
    check("rst_halt",   halt_a, 1'b0);
    check("rst_regs",   {acc_a, x_a, y_a}, 24'h000000);
    check("rst_pc",     pc_a,   16'h0000);
    check("rst_status", st_a,   8'h34);

    rst_a = 1'b0;
    clk_n(2);
    check("vec_pc",   pc_a,   16'h8000);
    check("vec_addr", addr_a, 16'h8000);

    clk_n(2);
    check("lda_imm_a",    acc_a,  8'h00);
    check("lda_imm_st",   st_a,   8'h36);
    check("lda_imm_done", done_a, 1'b1);
    check("lda_imm_addr", addr_a, 16'h8002);

    clk_n(2);
    check("ldx_imm_x",  x_a,  8'hFF);
    check("ldx_imm_st", st_a, 8'hB4);
    check("ldx_imm_pc", pc_a, 16'h8004);

    clk_n(3);
    dv_a = 1'b0;
    clk_n(3);
    check("stall_addr", addr_a, 16'h1234);
    check("stall_a",    acc_a,  8'h00);
    check("stall_dvo",  dvo_a,  1'b0);
    check("stall_do",   do_a,   8'h00);
    dv_a = 1'b1;
    clk_n(1);
    check("lda_abs_a",    acc_a,  8'h5A);
    check("lda_abs_st",   st_a,   8'h34);
    check("lda_abs_pc",   pc_a,   16'h8007);
    check("lda_abs_done", done_a, 1'b1);

    clk_n(2);
    check("nop_pc",   pc_a,   16'h8008);
    check("nop_done", done_a, 1'b1);

    clk_n(1);
`ifdef CPU_ILLEGAL_OP_TRAP_EN
    check("trap_halt", halt_a, 1'b1);
    check("trap_pc",   pc_a,   16'h8008);
    check("trap_av",   av_a,   1'b0);
    check("trap_done", done_a, 1'b0);
    clk_n(4);
    check("trap_halt_hold", halt_a, 1'b1);
    check("trap_pc_hold",   pc_a,   16'h8008);
    check("trap_done_hold", done_a, 1'b0);
`else
    check("illop_halt0", halt_a, 1'b0);
    check("illop_done0", done_a, 1'b0);
    clk_n(1);
    check("illop_pc",   pc_a,   16'h8009);
    check("illop_done", done_a, 1'b1);
    check("illop_halt", halt_a, 1'b0);
`endif

    // dut_b: divider 12, PC wrap, write strobe, reset during write
    rst_b = 1'b0;
    clk_n(11);
    check("div_pre_tick",  addr_b, 16'hFFFC);
    clk_n(1);
    check("div_first_tick", addr_b, 16'hFFFD);
    clk_n(36);
    check("wrap_a",  acc_b, 8'h42);
    check("wrap_pc", pc_b,  16'h0001);

    clk_n(48);
    hi_cnt = 0; rise_cnt = 0; done_cnt = 0; prev_s = 1'b0;
    w_addr = 16'h0000; w_data = 8'h00; w_av = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (dvo_b) begin
        hi_cnt++;
        if (!prev_s) begin
          rise_cnt++;
          w_addr = addr_b;
          w_data = do_b;
          w_av   = av_b;
        end
      end
      prev_s = dvo_b;
      if (done_b) done_cnt++;
    end
    check("sty_y",        y_b,      8'h77);
    check("wr_strobes",   rise_cnt, 1);
    check("wr_width",     hi_cnt,   12);
    check("wr_addr",      w_addr,   16'h0200);
    check("wr_data",      w_data,   8'h77);
    check("wr_av",        w_av,     1'b1);
    check("wr_done_once", done_cnt, 1);

    clk_n(12);
    check("sta_zp_dvo",  dvo_b,  1'b1);
    check("sta_zp_addr", addr_b, 16'h0010);
    check("sta_zp_data", do_b,   8'h42);
    clk_n(3);
    rst_b = 1'b1;
    clk_n(1);
    check("abort_dvo",  dvo_b,  1'b0);
    check("abort_addr", addr_b, 16'hFFFC);
    check("abort_do",   do_b,   8'h00);
    check("abort_done", done_b, 1'b0);
    clk_n(15);
    check("abort_no_strobe", dvo_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter CLOCK_DIVIDER, default 12: number of clock_i cycles per CPU tick; legal range 1..255.
REQ-002 Parameter RESET_VECTOR, default 16'hFFFC: address of the low byte of the start address; the high byte is read from RESET_VECTOR+1.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clock_i  input  1  system clock.
REQ-005 reset_i  input  1  synchronous active-high reset.
REQ-006 data_i  input  8  read data from memory.
REQ-007 data_valid_i  input  1  read data valid; sampled only on ticks.
REQ-008 address_o  output  16  bus address.
REQ-009 address_valid_o  output  1  address_o is valid.
REQ-010 data_o  output  8  write data.
REQ-011 data_valid_o  output  1  write strobe; address_o/data_o form a write.
REQ-012 instr_done_o  output  1  one-clock pulse on the clock an instruction retires.
REQ-013 halted_o  output  1  core is in HALT.
REQ-014 program_counter_o 16, accumulator_o 8, index_x_o 8, index_y_o 8, status_o 8  outputs  architectural register values.

Function
REQ-015 A tick SHALL occur on exactly one clock in every CLOCK_DIVIDER; state changes and register updates happen only on ticks.
REQ-016 The first tick SHALL occur CLOCK_DIVIDER clocks after reset_i deasserts; CLOCK_DIVIDER=1 SHALL give a tick every clock.
REQ-017 Read handshake: a read completes on a tick with data_valid_i=1; with data_valid_i=0 the state and address_o SHALL hold (stall), with no timeout.
REQ-018 Write handshake: data_valid_o=1 SHALL be held for one full tick period with address_valid_o=1; the write completes on the next tick regardless of data_valid_i.
REQ-019 States: RESET_LO, RESET_HI, FETCH, OPERAND_LO, OPERAND_HI, READ, WRITE, HALT.
REQ-020 RESET_LO reads RESET_VECTOR into PC[7:0], then goes to RESET_HI. RESET_HI reads RESET_VECTOR+1 into PC[15:8], then goes to FETCH with address_o equal to the new PC.
REQ-021 Supported opcodes, with ticks per instruction excluding stalls:
- NOP EA (2).
- LDA A9/A5/AD, LDX A2/A6/AE, LDY A0/A4/AC: immediate (2), zero-page (3), absolute (4).
- STA 85/8D, STX 86/8E, STY 84/8C: zero-page (3), absolute (4).
REQ-022 Zero-page effective address SHALL be {8'h00, operand}; absolute effective address SHALL be {operand_hi, operand_lo}, little-endian.
REQ-023 PC SHALL advance by 1 per opcode or operand byte consumed and wrap FFFF->0000; the operand fetch after FFFF reads 0000.
REQ-024 Loads SHALL set status bit 7 (N) to data[7] and bit 1 (Z) to (data==0); stores and NOP leave status unchanged.
REQ-025 On retirement, instr_done_o SHALL pulse, address_o SHALL equal the next PC, and the state SHALL return to FETCH.
REQ-026 During a stall, data_o and data_valid_o SHALL be 0 outside WRITE.

Reset
REQ-027 With reset_i=1 on a clock edge, the following SHALL hold on the next clock:
- state RESET_LO.
- address_o=RESET_VECTOR, address_valid_o=1.
- data_valid_o=0, data_o=0, instr_done_o=0, halted_o=0.
- A=X=Y=0, PC=0, status=8'h34.
- tick counter 0.
REQ-028 Reset asserted mid-instruction, mid-stall or mid-write SHALL abort the operation immediately with no further write strobe.

Configuration
REQ-029 Macro CPU_ILLEGAL_OP_TRAP_EN defined: an unsupported opcode SHALL enter HALT, set halted_o=1, drop address_valid_o, freeze PC at the opcode address and produce no instr_done_o pulse; only reset exits HALT.
REQ-030 Macro CPU_ILLEGAL_OP_TRAP_EN undefined: an unsupported opcode SHALL execute as a 2-tick NOP and halted_o SHALL be tied 0.

Structure
REQ-031 Package cpu_pkg SHALL hold:
- opcode localparams.
- the state enum typedef.
- status bit index constants (N=7, Z=1).
- the status reset value 8'h34.
REQ-032 Tick generation SHALL be the sub-module cpu_tick_divider (parameter CLOCK_DIVIDER; ports clock_i, reset_i, tick_o).

Verification
REQ-033 CLOCK_DIVIDER=1, vector FFFC/FFFD = 00/80 -> PC=8000, first fetch address_o=8000 after 2 ticks.
REQ-034 Program A9 00 at 8000 -> A=00, Z=1, N=0, instr_done_o at tick 2; then A2 FF -> X=FF, N=1, Z=0.
REQ-035 AD 34 12 with mem[1234]=5A and data_valid_i held low 3 ticks on the final read -> A=5A after 7 ticks, PC=8003.
REQ-036 A0 77 then 8C 00 02 -> one write strobe at address 0200 with data 77 for exactly CLOCK_DIVIDER clocks (CLOCK_DIVIDER=12).
REQ-037 Opcode 02 -> with CPU_ILLEGAL_OP_TRAP_EN, halted_o=1 and PC frozen; without it, 2-tick NOP and PC+1.
REQ-038 Reset asserted during the WRITE tick of 85 10 -> data_valid_o=0 on the next clock and address_o=FFFC.
